// File: rtl/fpu_scoreboard_if.sv
// fpu_scoreboard_if: ID/EX-side signals exchanged between the FP pipeline and its scoreboard
interface fpu_scoreboard_if #(
    parameter int LAT_W = 4
);
    logic             id_valid;
    logic             id_fp_write;
    logic [4:0]       id_rd;
    logic [LAT_W-1:0] id_latency;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rs3;
    logic             id_use1;
    logic             id_use2;
    logic             id_use3;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rs3;
    logic             hold;
    logic             flush;
    logic             stall_id;
    logic [1:0]       rs1_stage;
    logic [1:0]       rs2_stage;
    logic [1:0]       rs3_stage;
    logic [31:0]      busy_mask;

    modport master (
        output id_valid, id_fp_write, id_rd, id_latency,
        output id_rs1, id_rs2, id_rs3, id_use1, id_use2, id_use3,
        output ex_rs1, ex_rs2, ex_rs3, hold, flush,
        input  stall_id, rs1_stage, rs2_stage, rs3_stage, busy_mask
    );

    modport slave (
        input  id_valid, id_fp_write, id_rd, id_latency,
        input  id_rs1, id_rs2, id_rs3, id_use1, id_use2, id_use3,
        input  ex_rs1, ex_rs2, ex_rs3, hold, flush,
        output stall_id, rs1_stage, rs2_stage, rs3_stage, busy_mask
    );
endinterface

// File: rtl/fpu_scoreboard.sv
// fpu_scoreboard: tracks in-flight FP register writes through EX/MEM/WB and raises ID hazard stalls
module fpu_scoreboard #(
    parameter int LAT_W = 4
) (
    input logic            clk,
    input logic            rst,
    fpu_scoreboard_if.slave sb
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WB   = 2'b01,
        ST_MEM  = 2'b10,
        ST_EX   = 2'b11
    } stage_t;

    stage_t           stg     [32];
    stage_t           stg_nxt [32];
    logic [LAT_W-1:0] cnt     [32];
    logic [LAT_W-1:0] cnt_nxt [32];
    logic [LAT_W-1:0] l_eff;
    logic             raw;
    logic             waw;
    logic             slot;
    logic             issue;

    assign l_eff = (sb.id_latency == '0) ? LAT_W'(1) : sb.id_latency;

    // Hazard detection from current entry state; a producer with one EX cycle left forwards from MEM
    always_comb begin
        raw = (sb.id_use1 && sb.id_rs1 != 5'd0 && stg[sb.id_rs1] == ST_EX && cnt[sb.id_rs1] > LAT_W'(1)) ||
              (sb.id_use2 && sb.id_rs2 != 5'd0 && stg[sb.id_rs2] == ST_EX && cnt[sb.id_rs2] > LAT_W'(1)) ||
              (sb.id_use3 && sb.id_rs3 != 5'd0 && stg[sb.id_rs3] == ST_EX && cnt[sb.id_rs3] > LAT_W'(1));
        waw = sb.id_fp_write && sb.id_rd != 5'd0 && stg[sb.id_rd] == ST_EX;
        slot = 1'b0;
        for (int r = 1; r < 32; r++)
            slot = slot || (stg[r] == ST_EX && {1'b0, cnt[r]} == {1'b0, l_eff} + (LAT_W+1)'(1));
        slot = slot && sb.id_fp_write && sb.id_rd != 5'd0;
    end

    assign sb.stall_id = sb.id_valid && !sb.flush && (raw || waw || slot);
    assign issue = sb.id_valid && sb.id_fp_write && sb.id_rd != 5'd0 &&
                   !sb.stall_id && !sb.hold && !sb.flush;

    // Per-register next stage: a fresh issue overrides the entry's own advance
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            stg_nxt[r] = stg[r];
            cnt_nxt[r] = cnt[r];
            if (r != 0 && !sb.hold) begin
                if (issue && sb.id_rd == 5'(r)) begin
                    stg_nxt[r] = ST_EX;
                    cnt_nxt[r] = l_eff;
                end else begin
                    case (stg[r])
                        ST_EX:   if (cnt[r] > LAT_W'(1)) cnt_nxt[r] = cnt[r] - LAT_W'(1);
                                 else stg_nxt[r] = ST_MEM;
                        ST_MEM:  stg_nxt[r] = ST_WB;
                        ST_WB:   stg_nxt[r] = ST_IDLE;
                        default: stg_nxt[r] = ST_IDLE;
                    endcase
                end
            end
        end
    end

    // Entry state registers; reset discards all tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                stg[r] <= ST_IDLE;
                cnt[r] <= '0;
            end
        end else begin
            stg <= stg_nxt;
            cnt <= cnt_nxt;
        end
    end

    assign sb.rs1_stage = (sb.ex_rs1 == 5'd0) ? 2'b00 : stg[sb.ex_rs1];
    assign sb.rs2_stage = (sb.ex_rs2 == 5'd0) ? 2'b00 : stg[sb.ex_rs2];
    assign sb.rs3_stage = (sb.ex_rs3 == 5'd0) ? 2'b00 : stg[sb.ex_rs3];

    // Busy bit per register; f0 is never tracked
    always_comb begin
        sb.busy_mask = '0;
        for (int r = 1; r < 32; r++)
            sb.busy_mask[r] = (stg[r] != ST_IDLE);
    end
endmodule

// File: tb/tb_fpu_scoreboard.sv
// tb_fpu_scoreboard: directed and randomized checks of fpu_scoreboard against a writer-age model
module tb_fpu_scoreboard;
    localparam int LAT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    fpu_scoreboard_if #(.LAT_W(LAT_W)) sb ();
    fpu_scoreboard #(.LAT_W(LAT_W)) dut (.clk(clk), .rst(rst), .sb(sb));

    always #5 clk = ~clk;

    // Model: each tracked register remembers how many unfrozen cycles its writer has aged and its latency
    bit          m_valid [32];
    int          m_age   [32];
    int          m_lat   [32];
    logic        exp_stall;
    logic [31:0] exp_busy;

    function automatic logic [1:0] m_stage(int r);
        if (r == 0 || !m_valid[r]) return 2'b00;
        if (m_age[r] < m_lat[r]) return 2'b11;
        if (m_age[r] == m_lat[r]) return 2'b10;
        return 2'b01;
    endfunction

    function automatic int ex_left(int r);
        return (m_stage(r) == 2'b11) ? m_lat[r] - m_age[r] : 0;
    endfunction

    function automatic int l_of(logic [LAT_W-1:0] lat);
        return (lat == 0) ? 1 : int'(lat);
    endfunction

    task automatic model_eval();
        logic raw, waw, slot;
        raw = (sb.id_use1 && ex_left(int'(sb.id_rs1)) > 1) ||
              (sb.id_use2 && ex_left(int'(sb.id_rs2)) > 1) ||
              (sb.id_use3 && ex_left(int'(sb.id_rs3)) > 1);
        waw = sb.id_fp_write && sb.id_rd != 0 && ex_left(int'(sb.id_rd)) > 0;
        slot = 1'b0;
        for (int r = 1; r < 32; r++)
            if (ex_left(r) == l_of(sb.id_latency) + 1) slot = 1'b1;
        slot = slot && sb.id_fp_write && sb.id_rd != 0;
        exp_stall = sb.id_valid && !sb.flush && (raw || waw || slot);
        exp_busy = '0;
        for (int r = 1; r < 32; r++) exp_busy[r] = (m_stage(r) != 2'b00);
    endtask

    task automatic tick();
        logic iss;
        int   rd, l;
        model_eval();
        iss = sb.id_valid && sb.id_fp_write && sb.id_rd != 0 && !exp_stall && !sb.hold && !sb.flush;
        rd = int'(sb.id_rd);
        l = l_of(sb.id_latency);
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < 32; r++) m_valid[r] = 1'b0;
        end else if (!sb.hold) begin
            for (int r = 1; r < 32; r++)
                if (m_valid[r]) begin
                    m_age[r]++;
                    if (m_age[r] > m_lat[r] + 1) m_valid[r] = 1'b0;
                end
            if (iss) begin
                m_valid[rd] = 1'b1;
                m_age[rd] = 0;
                m_lat[rd] = l;
            end
        end
        #2;
    endtask

    task automatic drive_idle();
        rst = 1'b0;
        sb.id_valid = 1'b0; sb.id_fp_write = 1'b0; sb.id_rd = '0; sb.id_latency = '0;
        sb.id_rs1 = '0; sb.id_rs2 = '0; sb.id_rs3 = '0;
        sb.id_use1 = 1'b0; sb.id_use2 = 1'b0; sb.id_use3 = 1'b0;
        sb.ex_rs1 = '0; sb.ex_rs2 = '0; sb.ex_rs3 = '0;
        sb.hold = 1'b0; sb.flush = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [LAT_W-1:0] lat);
        drive_idle();
        sb.id_valid = 1'b1; sb.id_fp_write = 1'b1; sb.id_rd = rd; sb.id_latency = lat;
        tick();
        drive_idle();
    endtask

    task automatic test_reset();
        do_reset();
        sb.ex_rs1 = 5'd5; sb.ex_rs2 = 5'd3; sb.ex_rs3 = 5'd31;
        #1;
        checks++; if (sb.busy_mask !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp 0", sb.busy_mask); end
        checks++; if (sb.stall_id !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", sb.stall_id); end
        checks++; if ({sb.rs1_stage, sb.rs2_stage, sb.rs3_stage} !== 6'b0)
            begin errors++; $display("FAIL reset_stages got %b exp 000000", {sb.rs1_stage, sb.rs2_stage, sb.rs3_stage}); end
        drive_idle();
    endtask

    task automatic test_basic();
        logic [1:0] seq [4];
        seq = '{2'b11, 2'b10, 2'b01, 2'b00};
        issue(5'd5, 4'd1);
        sb.ex_rs1 = 5'd5;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (sb.rs1_stage !== seq[i]) begin errors++; $display("FAIL basic_stage[%0d] got %b exp %b", i, sb.rs1_stage, seq[i]); end
            checks++; if (sb.busy_mask[5] !== logic'(i < 3)) begin errors++; $display("FAIL basic_busy[%0d] got %b exp %b", i, sb.busy_mask[5], i < 3); end
            tick();
            #1;
        end
    endtask

    task automatic test_raw();
        int n = 0;
        bit done = 1'b0;
        do_reset();
        issue(5'd3, 4'd4);
        sb.id_valid = 1'b1; sb.id_rs1 = 5'd3; sb.id_use1 = 1'b1;
        for (int i = 0; i < 8 && !done; i++) begin
            #1;
            model_eval();
            checks++; if (sb.stall_id !== exp_stall) begin errors++; $display("FAIL raw_stall[%0d] got %b exp %b", i, sb.stall_id, exp_stall); end
            if (sb.stall_id) begin n++; tick(); end else done = 1'b1;
        end
        checks++; if (n != 3) begin errors++; $display("FAIL raw_stall_cycles got %0d exp 3", n); end
        tick();
        drive_idle();
        sb.ex_rs1 = 5'd3;
        #1;
        checks++; if (sb.rs1_stage !== 2'b10) begin errors++; $display("FAIL raw_ex_stage got %b exp 10", sb.rs1_stage); end
    endtask

    task automatic test_slot();
        do_reset();
        issue(5'd7, 4'd3);
        sb.id_valid = 1'b1; sb.id_fp_write = 1'b1; sb.id_rd = 5'd8; sb.id_latency = 4'd2;
        #1;
        checks++; if (sb.stall_id !== 1'b1) begin errors++; $display("FAIL slot_stall got %b exp 1", sb.stall_id); end
        tick();
        #1;
        checks++; if (sb.stall_id !== 1'b0) begin errors++; $display("FAIL slot_release got %b exp 0", sb.stall_id); end
        tick();
        do_reset();
        issue(5'd7, 4'd3);
        sb.id_valid = 1'b1; sb.id_fp_write = 1'b1; sb.id_rd = 5'd8; sb.id_latency = 4'd1;
        #1;
        checks++; if (sb.stall_id !== 1'b0) begin errors++; $display("FAIL slot_l1 got %b exp 0", sb.stall_id); end
        sb.id_rd = 5'd0; sb.id_latency = 4'd2;
        #1;
        checks++; if (sb.stall_id !== 1'b0) begin errors++; $display("FAIL slot_f0 got %b exp 0", sb.stall_id); end
        drive_idle();
    endtask

    task automatic test_waw();
        int n = 0;
        bit done = 1'b0;
        do_reset();
        issue(5'd9, 4'd2);
        sb.id_valid = 1'b1; sb.id_fp_write = 1'b1; sb.id_rd = 5'd9; sb.id_latency = 4'd5;
        for (int i = 0; i < 8 && !done; i++) begin
            #1;
            model_eval();
            checks++; if (sb.stall_id !== exp_stall) begin errors++; $display("FAIL waw_stall[%0d] got %b exp %b", i, sb.stall_id, exp_stall); end
            if (sb.stall_id) begin n++; tick(); end else done = 1'b1;
        end
        checks++; if (n != 2) begin errors++; $display("FAIL waw_stall_cycles got %0d exp 2", n); end
        tick();
        drive_idle();
        sb.ex_rs1 = 5'd9;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (sb.rs1_stage !== 2'b11) begin errors++; $display("FAIL waw_new_ex[%0d] got %b exp 11", i, sb.rs1_stage); end
            tick();
            #1;
        end
        checks++; if (sb.rs1_stage !== 2'b10) begin errors++; $display("FAIL waw_new_mem got %b exp 10", sb.rs1_stage); end
    endtask

    task automatic test_hold_flush();
        do_reset();
        issue(5'd4, 4'd1);
        tick();
        sb.ex_rs1 = 5'd4; sb.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (sb.rs1_stage !== 2'b10) begin errors++; $display("FAIL hold_stage[%0d] got %b exp 10", i, sb.rs1_stage); end
            tick();
        end
        sb.hold = 1'b0;
        tick();
        #1;
        checks++; if (sb.rs1_stage !== 2'b01) begin errors++; $display("FAIL hold_resume got %b exp 01", sb.rs1_stage); end
        do_reset();
        issue(5'd6, 4'd3);
        sb.id_valid = 1'b1; sb.id_fp_write = 1'b1; sb.id_rd = 5'd6; sb.id_latency = 4'd5; sb.flush = 1'b1;
        #1;
        checks++; if (sb.stall_id !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", sb.stall_id); end
        tick();
        sb.id_rd = 5'd10;
        tick();
        drive_idle();
        sb.ex_rs1 = 5'd6;
        tick();
        #1;
        checks++; if (sb.rs1_stage !== 2'b10) begin errors++; $display("FAIL flush_no_issue got %b exp 10", sb.rs1_stage); end
        checks++; if (sb.busy_mask[10] !== 1'b0) begin errors++; $display("FAIL flush_no_entry got %b exp 0", sb.busy_mask[10]); end
    endtask

    task automatic test_edge();
        do_reset();
        issue(5'd0, 4'd3);
        #1;
        checks++; if (sb.busy_mask !== 32'h0) begin errors++; $display("FAIL f0_busy got %h exp 0", sb.busy_mask); end
        checks++; if (sb.rs1_stage !== 2'b00) begin errors++; $display("FAIL f0_stage got %b exp 00", sb.rs1_stage); end
        issue(5'd11, 4'd0);
        sb.ex_rs1 = 5'd11;
        #1;
        checks++; if (sb.rs1_stage !== 2'b11) begin errors++; $display("FAIL lat0_ex got %b exp 11", sb.rs1_stage); end
        tick();
        #1;
        checks++; if (sb.rs1_stage !== 2'b10) begin errors++; $display("FAIL lat0_mem got %b exp 10", sb.rs1_stage); end
        issue(5'd12, 4'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (sb.busy_mask !== 32'h0) begin errors++; $display("FAIL midflight_reset got %h exp 0", sb.busy_mask); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 500; c++) begin
            rst = ($urandom_range(0, 99) < 2);
            sb.id_valid = ($urandom_range(0, 3) != 0);
            sb.id_fp_write = ($urandom_range(0, 3) != 0);
            sb.id_rd = 5'($urandom_range(0, 7));
            sb.id_latency = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
            sb.id_rs1 = 5'($urandom_range(0, 7)); sb.id_rs2 = 5'($urandom_range(0, 7)); sb.id_rs3 = 5'($urandom_range(0, 7));
            sb.id_use1 = 1'($urandom_range(0, 1)); sb.id_use2 = 1'($urandom_range(0, 1)); sb.id_use3 = 1'($urandom_range(0, 1));
            sb.ex_rs1 = 5'($urandom_range(0, 7)); sb.ex_rs2 = 5'($urandom_range(0, 7)); sb.ex_rs3 = 5'($urandom_range(0, 7));
            sb.hold = ($urandom_range(0, 9) == 0);
            sb.flush = ($urandom_range(0, 9) == 0);
            #1;
            model_eval();
            checks++; if (sb.stall_id !== exp_stall) begin errors++; $display("FAIL rnd_stall[%0d] got %b exp %b", c, sb.stall_id, exp_stall); end
            checks++; if (sb.rs1_stage !== m_stage(int'(sb.ex_rs1))) begin errors++; $display("FAIL rnd_rs1[%0d] got %b exp %b", c, sb.rs1_stage, m_stage(int'(sb.ex_rs1))); end
            checks++; if (sb.rs2_stage !== m_stage(int'(sb.ex_rs2))) begin errors++; $display("FAIL rnd_rs2[%0d] got %b exp %b", c, sb.rs2_stage, m_stage(int'(sb.ex_rs2))); end
            checks++; if (sb.rs3_stage !== m_stage(int'(sb.ex_rs3))) begin errors++; $display("FAIL rnd_rs3[%0d] got %b exp %b", c, sb.rs3_stage, m_stage(int'(sb.ex_rs3))); end
            checks++; if (sb.busy_mask !== exp_busy) begin errors++; $display("FAIL rnd_busy[%0d] got %h exp %h", c, sb.busy_mask, exp_busy); end
            tick();
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        #2;
        test_reset();
        test_basic();
        test_raw();
        test_slot();
        test_waw();
        test_hold_flush();
        test_edge();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout reached without completing the test sequence");
        $fatal(1, "timeout");
    end
endmodule
